double_buffer_ctrl: RTL and testbench
=====================================

# double_buffer_ctrl

Sequencer for the `double_buffer` bank pair: accepts a producer write stream, issues per-bank write and read addresses, and pulses `switch_banks` when the fill bank is full and the drain bank is finished. The drain bank is re-read `drain_reps` times for operand reuse. It sits between the input streamer and the PE array, with `double_buffer` as its only datapath.

## Interface
Parameters:
- BANK_ADDR_WIDTH, 7, address width per bank; addresses run 0..2^BANK_ADDR_WIDTH-1 within a bank.
- REP_WIDTH, 8, width of `drain_reps`.
- CNT_WIDTH, 16, width of `num_banks` and the bank counters.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle pulse; samples cfg_*; ignored while busy.
- cfg_fill_len  in  BANK_ADDR_WIDTH  words per bank minus 1.
- cfg_drain_len  in  BANK_ADDR_WIDTH  words read per pass minus 1.
- cfg_drain_reps  in  REP_WIDTH  read passes per bank minus 1.
- cfg_num_banks  in  CNT_WIDTH  banks in the job minus 1.
- wvalid  in  1  producer word valid.
- wready  out  1  controller accepts the word.
- rstall  in  1  consumer stall; blocks new reads.
- wen, wadr  out  1 / BANK_ADDR_WIDTH  write port to `double_buffer`.
- ren, radr  out  1 / BANK_ADDR_WIDTH  read port to `double_buffer`.
- switch_banks  out  1  bank swap to `double_buffer`.
- rvalid  out  1  `double_buffer` rdata valid this cycle.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse when the job is complete.

## Operation
- Minus-1 encoding on every cfg field, so zero is legal and means one word, one pass, or one bank.
- Write FSM states:
  - W_FILL: `wready` = 1; each accepted word increments `wadr`. On the accept with `wadr` == fill_len, `wadr` goes to 0 and the FSM moves to W_FULL.
  - W_FULL: `wready` = 0; waits for a swap.
  - W_DONE: all banks filled; `wready` = 0.
- Read FSM states:
  - R_IDLE: no bank to drain, or the current bank is finished.
  - R_DRAIN: `ren` = !rstall; each issued read increments `radr`. At `radr` == drain_len, `radr` goes to 0 and the rep counter increments. After the last rep the FSM moves to R_IDLE.
- Swap: `switch_banks` = busy & W_FULL & R_IDLE, combinational from registered state. On that edge:
  - The read FSM enters R_DRAIN with `radr` = 0 and rep = 0, and `banks_swapped` increments.
  - The write FSM enters W_FILL, or W_DONE if `banks_swapped` reaches num_banks+1.
- Completion: the last read of the last rep of bank num_banks asserts `done` on the next cycle, clears `busy`, and returns both FSMs to the not-busy state.
- `start` puts the write FSM in W_FILL and the read FSM in R_IDLE, and clears all counters.
- Every comparison is exact equality at the configured width. No counter wraps past its limit.

## Timing
- Reset: `wready`, `wen`, `ren`, `switch_banks`, `rvalid`, `busy` and `done` are all 0; `wadr` and `radr` are 0. Reset in the middle of a job abandons it, with no `done`.
- `wen` = wvalid & wready (combinational); `wadr` is registered.
- `ren` and `radr` are registered-state driven. `rvalid` is `ren` delayed one cycle, matching the 1-cycle SRAM latency.
- The final write of a bank and the swap never share a cycle: minimum one cycle in W_FULL.
- No read is issued in a swap cycle (R_IDLE), so reads never straddle banks.
- `rstall` high freezes `radr` and the rep counter. An `rvalid` already in flight still appears.
- A start pulse while busy has no effect. `busy` rises the cycle after start.

## Configuration
- DB_CTRL_PERF_EN defined: two CNT_WIDTH-wide saturating output counters are added, both cleared on start:
  - `perf_wr_block`: cycles with W_FULL & wvalid.
  - `perf_rd_starve`: busy cycles in R_IDLE with no swap.
- DB_CTRL_PERF_EN undefined: the ports and logic are absent. Functional behaviour is identical either way.

## Structure
- Shared package `db_ctrl_pkg` holds:
  - enum `wr_state_t` {W_FILL, W_FULL, W_DONE}
  - enum `rd_state_t` {R_IDLE, R_DRAIN}
  - parameter defaults
- One sub-module, `db_addr_counter`: an address counter with configurable limit, enable and last flag. It is instantiated for `wadr`, `radr` and the rep count.

## Test plan
- fill_len=3, drain_len=3, reps=0, num_banks=1, wvalid always 1 -> writes 0-3, `switch_banks` pulse, then bank 2 writes overlap bank 1 reads. 2 swaps, 8 `rvalid`, `done` one cycle after the last `rvalid`'s read.
- reps=2, drain_len=1, num_banks=0 -> `radr` sequence 0,1,0,1,0,1, then `done`. Only one `switch_banks` over the whole job.
- Slow consumer: rstall toggles 1-0 during a drain -> `wready` stays 0 in W_FULL until the drain completes, and the swap occurs the cycle after R_IDLE.
- Gapped wvalid, fill_len=7 -> `wadr` advances only on accepted cycles, and W_FULL is entered after exactly 8 accepts.
- rst high mid-drain -> next cycle all outputs are 0 and no `done`. A start issued afterwards runs the job cleanly.
- start while busy with different cfg -> ignored, and the original job finishes with the original lengths.

Source files
------------

// File: rtl/db_ctrl_pkg.sv
// db_ctrl_pkg: shared state encodings and parameter defaults for the double-buffer controller
package db_ctrl_pkg;
    localparam int BANK_ADDR_WIDTH_DEF = 7;
    localparam int REP_WIDTH_DEF = 8;
    localparam int CNT_WIDTH_DEF = 16;
    typedef enum logic [1:0] {W_FILL, W_FULL, W_DONE} wr_state_t;
    typedef enum logic {R_IDLE, R_DRAIN} rd_state_t;
endpackage

// File: rtl/db_addr_counter.sv
// db_addr_counter: wrapping counter with clear, enable and a flag raised at the configured limit
module db_addr_counter #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] limit,
    output logic [W-1:0] cnt,
    output logic         last
);
    logic [W-1:0] cnt_q, cnt_d;
    assign cnt = cnt_q;
    assign last = cnt_q == limit;
    always_comb cnt_d = clr ? '0 : en ? (last ? '0 : cnt_q + 1'b1) : cnt_q;
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/double_buffer_ctrl.sv
// double_buffer_ctrl: write/read sequencer for a ping-pong bank pair with repeated drains.
// Defining DB_CTRL_PERF_EN adds saturating stall/starve performance counters.
module double_buffer_ctrl
    import db_ctrl_pkg::*;
#(
    parameter int BANK_ADDR_WIDTH = BANK_ADDR_WIDTH_DEF,
    parameter int REP_WIDTH = REP_WIDTH_DEF,
    parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [BANK_ADDR_WIDTH-1:0] cfg_fill_len,
    input  logic [BANK_ADDR_WIDTH-1:0] cfg_drain_len,
    input  logic [REP_WIDTH-1:0]       cfg_drain_reps,
    input  logic [CNT_WIDTH-1:0]       cfg_num_banks,
    input  logic                       wvalid,
    output logic                       wready,
    input  logic                       rstall,
    output logic                       wen,
    output logic [BANK_ADDR_WIDTH-1:0] wadr,
    output logic                       ren,
    output logic [BANK_ADDR_WIDTH-1:0] radr,
    output logic                       switch_banks,
    output logic                       rvalid,
    output logic                       busy,
`ifdef DB_CTRL_PERF_EN
    output logic [CNT_WIDTH-1:0]       perf_wr_block,
    output logic [CNT_WIDTH-1:0]       perf_rd_starve,
`endif
    output logic                       done
);
    wr_state_t wr_state_q, wr_state_d;
    rd_state_t rd_state_q, rd_state_d;
    logic busy_q, busy_d, done_q, done_d, rvalid_q, rvalid_d;
    logic [BANK_ADDR_WIDTH-1:0] fill_len_q, fill_len_d, drain_len_q, drain_len_d;
    logic [REP_WIDTH-1:0] reps_q, reps_d, rep;
    logic [CNT_WIDTH-1:0] num_banks_q, num_banks_d, swapped_q, swapped_d;
    logic start_ok, wadr_last, radr_last, rep_last, pass_end, job_end;

    assign start_ok = start & ~busy_q;
    assign wready = busy_q & (wr_state_q == W_FILL);
    assign wen = wvalid & wready;
    assign ren = busy_q & (rd_state_q == R_DRAIN) & ~rstall;
    assign switch_banks = busy_q & (wr_state_q == W_FULL) & (rd_state_q == R_IDLE);
    assign pass_end = ren & radr_last & rep_last;
    // W_DONE means the bank being drained is the final one
    assign job_end = pass_end & (wr_state_q == W_DONE);
    assign busy = busy_q;
    assign done = done_q;
    assign rvalid = rvalid_q;

    db_addr_counter #(.W(BANK_ADDR_WIDTH)) u_wadr (
        .clk(clk), .rst(rst), .clr(start_ok), .en(wen),
        .limit(fill_len_q), .cnt(wadr), .last(wadr_last)
    );
    db_addr_counter #(.W(BANK_ADDR_WIDTH)) u_radr (
        .clk(clk), .rst(rst), .clr(start_ok | switch_banks), .en(ren),
        .limit(drain_len_q), .cnt(radr), .last(radr_last)
    );
    db_addr_counter #(.W(REP_WIDTH)) u_rep (
        .clk(clk), .rst(rst), .clr(start_ok | switch_banks), .en(ren & radr_last),
        .limit(reps_q), .cnt(rep), .last(rep_last)
    );

    always_comb begin
        wr_state_d = wr_state_q;
        rd_state_d = rd_state_q;
        busy_d = busy_q;
        swapped_d = swapped_q;
        fill_len_d = fill_len_q;
        drain_len_d = drain_len_q;
        reps_d = reps_q;
        num_banks_d = num_banks_q;
        done_d = job_end;
        rvalid_d = ren;
        if (start_ok) begin
            fill_len_d = cfg_fill_len;
            drain_len_d = cfg_drain_len;
            reps_d = cfg_drain_reps;
            num_banks_d = cfg_num_banks;
            busy_d = 1'b1;
            wr_state_d = W_FILL;
            rd_state_d = R_IDLE;
            swapped_d = '0;
        end else if (job_end) begin
            busy_d = 1'b0;
            wr_state_d = W_FILL;
            rd_state_d = R_IDLE;
        end else begin
            if (wen && wadr_last) wr_state_d = W_FULL;
            if (switch_banks) begin
                rd_state_d = R_DRAIN;
                swapped_d = swapped_q + 1'b1;
                wr_state_d = (swapped_q == num_banks_q) ? W_DONE : W_FILL;
            end else if (pass_end) begin
                rd_state_d = R_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q <= W_FILL;
            rd_state_q <= R_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            rvalid_q <= 1'b0;
            swapped_q <= '0;
            fill_len_q <= '0;
            drain_len_q <= '0;
            reps_q <= '0;
            num_banks_q <= '0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            busy_q <= busy_d;
            done_q <= done_d;
            rvalid_q <= rvalid_d;
            swapped_q <= swapped_d;
            fill_len_q <= fill_len_d;
            drain_len_q <= drain_len_d;
            reps_q <= reps_d;
            num_banks_q <= num_banks_d;
        end
    end

`ifdef DB_CTRL_PERF_EN
    logic [CNT_WIDTH-1:0] wr_block_q, wr_block_d, rd_starve_q, rd_starve_d;
    logic wr_block_hit, rd_starve_hit;
    assign wr_block_hit = busy_q & (wr_state_q == W_FULL) & wvalid;
    assign rd_starve_hit = busy_q & (rd_state_q == R_IDLE) & ~switch_banks;
    assign perf_wr_block = wr_block_q;
    assign perf_rd_starve = rd_starve_q;
    always_comb begin
        wr_block_d = start_ok ? '0 : (wr_block_hit && !(&wr_block_q)) ? wr_block_q + 1'b1 : wr_block_q;
        rd_starve_d = start_ok ? '0 : (rd_starve_hit && !(&rd_starve_q)) ? rd_starve_q + 1'b1 : rd_starve_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_block_q <= '0;
            rd_starve_q <= '0;
        end else begin
            wr_block_q <= wr_block_d;
            rd_starve_q <= rd_starve_d;
        end
    end
`endif
endmodule

// File: tb/tb_double_buffer_ctrl.sv
// tb_double_buffer_ctrl: directed self-checking bench for double_buffer_ctrl
module tb_double_buffer_ctrl;
    logic clk = 0, rst = 1, start = 0, wvalid = 0, rstall = 0;
    logic [6:0] cfg_fill_len = 0, cfg_drain_len = 0;
    logic [7:0] cfg_drain_reps = 0;
    logic [15:0] cfg_num_banks = 0;
    logic wready, wen, ren, switch_banks, rvalid, busy, done;
    logic [6:0] wadr, radr;
`ifdef DB_CTRL_PERF_EN
    logic [15:0] perf_wr_block, perf_rd_starve;
`endif
    int n_checks = 0, n_fail = 0;
    int cyc = 0, ren_cnt, wen_cnt, sw_cnt, rv_cnt, done_cnt, rv_at_done, rv_cnt_at_done;
    int ren_cyc[64], sw_cyc[8], wen_at_sw[8];
    logic [63:0] rd_seq, wr_seq;

    double_buffer_ctrl dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_fill_len(cfg_fill_len), .cfg_drain_len(cfg_drain_len),
        .cfg_drain_reps(cfg_drain_reps), .cfg_num_banks(cfg_num_banks),
        .wvalid(wvalid), .wready(wready), .rstall(rstall),
        .wen(wen), .wadr(wadr), .ren(ren), .radr(radr),
        .switch_banks(switch_banks), .rvalid(rvalid), .busy(busy),
`ifdef DB_CTRL_PERF_EN
        .perf_wr_block(perf_wr_block), .perf_rd_starve(perf_rd_starve),
`endif
        .done(done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc++;
        if (ren) begin
            if (ren_cnt < 64) ren_cyc[ren_cnt] = cyc;
            ren_cnt++;
            rd_seq = {rd_seq[59:0], radr[3:0]};
        end
        if (wen) begin
            wen_cnt++;
            wr_seq = {wr_seq[59:0], wadr[3:0]};
        end
        if (switch_banks) begin
            if (sw_cnt < 8) begin
                sw_cyc[sw_cnt] = cyc;
                wen_at_sw[sw_cnt] = wen_cnt;
            end
            sw_cnt++;
        end
        if (rvalid) rv_cnt++;
        if (done) begin
            done_cnt++;
            rv_at_done = int'(rvalid);
            rv_cnt_at_done = rv_cnt;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        ren_cnt = 0; wen_cnt = 0; sw_cnt = 0; rv_cnt = 0; done_cnt = 0;
        rv_at_done = 0; rv_cnt_at_done = 0; rd_seq = 0; wr_seq = 0;
    endtask

    // wmode 1 gaps wvalid, rmode 1 toggles rstall; restart pulses a second start mid-job
    task automatic job(input logic [6:0] fl, input logic [6:0] dl, input logic [7:0] rp,
                       input logic [15:0] nb, input int wmode, input int rmode,
                       input bit restart, input bit abort);
        clear_logs();
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        cfg_fill_len = fl; cfg_drain_len = dl; cfg_drain_reps = rp; cfg_num_banks = nb;
        start = 1;
        @(posedge clk); #1;
        start = 0;
        check("busy_rise", busy, 1);
        for (int i = 0; i < 400 && done_cnt == 0; i++) begin
            wvalid = (wmode == 1) ? (i % 3 != 2) : 1'b1;
            rstall = (rmode == 1) ? (i % 2 == 0) : 1'b0;
            if (restart && i == 3) begin
                cfg_fill_len = 0; cfg_drain_len = 0; cfg_drain_reps = 5; cfg_num_banks = 3;
                start = 1;
            end else start = 0;
            if (abort && ren_cnt > 0) begin
                rst = 1;
                @(posedge clk); #1;
                rst = 0;
                check("rst_ctl", {wready, wen, ren, switch_banks, rvalid, busy, done}, 0);
                check("rst_adr", {wadr, radr}, 0);
                repeat (6) @(posedge clk);
                #1;
                check("rst_no_done", done_cnt, 0);
                check("rst_idle", busy, 0);
                wvalid = 0;
                return;
            end
            @(posedge clk); #1;
        end
        start = 0; wvalid = 0; rstall = 0;
        check("done_seen", done_cnt, 1);
        repeat (3) @(posedge clk);
        #1;
        check("done_once", done_cnt, 1);
        check("busy_clear", busy, 0);
    endtask

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ctl", {wready, wen, ren, switch_banks, rvalid, busy, done}, 0);
        check("reset_adr", {wadr, radr}, 0);
        rst = 0;

        job(3, 3, 0, 1, 0, 0, 0, 0);
        check("t1_swaps", sw_cnt, 2);
        check("t1_rvalid", rv_cnt, 8);
        check("t1_wen", wen_cnt, 8);
        check("t1_wseq", wr_seq, 64'h01230123);
        check("t1_rseq", rd_seq, 64'h01230123);
        check("t1_swap_gap", sw_cyc[1] - sw_cyc[0], 5);
        check("t1_done_rv", rv_at_done, 1);
        check("t1_done_rvcnt", rv_cnt_at_done, 8);

        job(1, 1, 2, 0, 0, 0, 0, 0);
        check("t2_rseq", rd_seq, 64'h010101);
        check("t2_reads", ren_cnt, 6);
        check("t2_swaps", sw_cnt, 1);

        job(1, 1, 1, 1, 0, 1, 0, 0);
        check("t3_rseq", rd_seq, 64'h01010101);
        check("t3_swaps", sw_cnt, 2);
        check("t3_wen_at_sw", wen_at_sw[1], 4);
        check("t3_swap_after", sw_cyc[1] - ren_cyc[3], 1);
        check("t3_rvalid", rv_cnt, 8);

        job(7, 0, 0, 0, 1, 0, 0, 0);
        check("t4_wseq", wr_seq, 64'h01234567);
        check("t4_accepts", wen_at_sw[0], 8);
        check("t4_swaps", sw_cnt, 1);
        check("t4_rvalid", rv_cnt, 1);

        job(3, 3, 0, 1, 0, 0, 0, 1);
        job(1, 1, 2, 0, 0, 0, 0, 0);
        check("t5_rseq", rd_seq, 64'h010101);
        check("t5_swaps", sw_cnt, 1);

        job(3, 3, 0, 1, 0, 0, 1, 0);
        check("t6_swaps", sw_cnt, 2);
        check("t6_rvalid", rv_cnt, 8);
        check("t6_wseq", wr_seq, 64'h01230123);
        check("t6_rseq", rd_seq, 64'h01230123);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
